// File: rtl/psum_collector.sv
// Deskews the skewed bottom-row psums of the systolic array into aligned rows
// and buffers them in a FIFO that drains through a valid/ready stream.
module psum_collector #(
  parameter int WIDTH = 8,
  parameter int COLS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Clear,
  input  logic                        Row_Valid,
  input  logic [COLS*2*WIDTH-1:0]     PsumIn,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic [COLS*2*WIDTH-1:0]     Out_Data,
  output logic                        Full,
  output logic [$clog2(DEPTH):0]      Count,
  output logic                        Overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int DW = COLS * PW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0]   w_aligned;
  logic [COLS-2:0] r_vpipe;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_push_ok;
  logic            w_drop;

  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  // Column c waits COLS-1-c cycles so every column lines up with the last one.
  for (genvar c = 0; c < COLS - 1; c++) begin : g_dly
    localparam int N = COLS - 1 - c;
    logic [PW-1:0] r_sh [N];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would collapse the shift chain.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        for (int k = 0; k < N; k++) r_sh[k] <= '0;
      end else if (Clear) begin
        for (int k = 0; k < N; k++) r_sh[k] <= '0;
      end else begin
        r_sh[0] <= PsumIn[c*PW +: PW];
        for (int k = 1; k < N; k++) r_sh[k] <= r_sh[k-1];
      end
    end

    assign w_aligned[c*PW +: PW] = r_sh[N-1];
  end

  assign w_aligned[(COLS-1)*PW +: PW] = PsumIn[(COLS-1)*PW +: PW];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       r_vpipe <= '0;
    else if (Clear) r_vpipe <= '0;
    else            r_vpipe <= (r_vpipe << 1) | (COLS-1)'(Row_Valid);
  end

  assign w_push = r_vpipe[COLS-2];

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_full    = 1'b0;
    w_pop     = 1'b0;
    w_push_ok = 1'b0;
    w_drop    = 1'b0;
    w_full    = (r_count == CW'(DEPTH));
    w_pop     = (r_count != '0) && Out_Ready;
    // A full FIFO still takes the row when the head leaves on the same edge.
    w_push_ok = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (Clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: the row storage has no reset; pointers and count define which
  // entries are live, and the output is gated to zero while empty.
  always_ff @(posedge CLK) begin
    if (w_push_ok && !Clear) r_mem[r_wr_ptr] <= w_aligned;
  end

  assign Out_Valid = (r_count != '0);
  assign Out_Data  = Out_Valid ? r_mem[r_rd_ptr] : '0;
  assign Full      = w_full;
  assign Count     = r_count;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: stimulus pushes expected rows into a
// queue, a negedge monitor pops and compares every accepted output row.
module tb_psum_collector;

  localparam int WIDTH = 8;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;
  localparam int PW    = 2 * WIDTH;
  localparam int DW    = COLS * PW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Clear;
  logic          Row_Valid;
  logic [DW-1:0] PsumIn;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [DW-1:0] Out_Data;
  logic          Full;
  logic [CW-1:0] Count;
  logic          Overflow;

  psum_collector #(.WIDTH(WIDTH), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .Clear(Clear), .Row_Valid(Row_Valid),
    .PsumIn(PsumIn), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Data(Out_Data), .Full(Full), .Count(Count), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int pop_cnt = 0;

  logic [DW-1:0] exp_q [$];
  logic          sl_v [COLS];
  logic [DW-1:0] sl_d [COLS];

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mk_row(input int base);
    logic [DW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*PW +: PW] = PW'(base + c);
    return r;
  endfunction

  // One clock: shift the skew model and drive column c of the row issued c cycles ago.
  task automatic step(input logic rv, input logic [DW-1:0] row, input logic rdy);
    @(posedge CLK);
    #1;
    for (int k = COLS - 1; k > 0; k--) begin
      sl_v[k] = sl_v[k-1];
      sl_d[k] = sl_d[k-1];
    end
    sl_v[0]   = rv;
    sl_d[0]   = row;
    Row_Valid = rv;
    Out_Ready = rdy;
    for (int c = 0; c < COLS; c++)
      PsumIn[c*PW +: PW] = sl_v[c] ? sl_d[c][c*PW +: PW] : PW'($urandom);
  endtask

  task automatic issue(input logic [DW-1:0] row, input logic rdy);
    step(1'b1, row, rdy);
    exp_q.push_back(row);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  task automatic flush_model();
    for (int k = 0; k < COLS; k++) begin
      sl_v[k] = 1'b0;
      sl_d[k] = '0;
    end
    exp_q.delete();
    Row_Valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, DW'(Out_Valid), '0);
    check({tag, "_count"},     DW'(Count),     '0);
    check({tag, "_full"},      DW'(Full),      '0);
    check({tag, "_out_data"},  Out_Data,       '0);
    check({tag, "_overflow"},  DW'(Overflow),  '0);
  endtask

  // Monitor: compares each accepted row and holds the head steady across stalls.
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_d = '0;
  always @(negedge CLK) begin
    if (!RST || Clear) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        check("stall_valid", DW'(Out_Valid), DW'(1));
        check("stall_data", Out_Data, stall_d);
      end
      if (Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_row: got %h expected none", Out_Data);
        end else begin
          check("row_data", Out_Data, exp_q.pop_front());
          pop_cnt++;
        end
      end
      stall_v = Out_Valid && !Out_Ready;
      stall_d = Out_Data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ov6;
    logic [9:0] ov10;
    logic       any_v;
    int         sent;
    int         pend;
    int         cyc;

    RST = 1'b0; Clear = 1'b0; Row_Valid = 1'b0; Out_Ready = 1'b0; PsumIn = '0;
    for (int k = 0; k < COLS; k++) begin sl_v[k] = 1'b0; sl_d[k] = '0; end
    #2;
    check_zero("reset");
    #10 RST = 1'b1;
    idle(2, 1'b1);

    // Single row: visible exactly in cycle 4.
    issue(mk_row(16'h0100), 1'b1);
    ov6[0] = Out_Valid;
    for (int i = 1; i < 6; i++) begin step(1'b0, '0, 1'b1); ov6[i] = Out_Valid; end
    check("single_valid_timing", DW'(ov6), DW'(6'b010000));
    check("single_count_back_0", DW'(Count), '0);
    check("single_sb_empty", DW'(exp_q.size()), '0);

    // Back-to-back rows: four consecutive output cycles 4..7.
    issue(mk_row(0), 1'b1);
    ov10[0] = Out_Valid;
    for (int r = 1; r < 4; r++) begin issue(mk_row(r * 16), 1'b1); ov10[r] = Out_Valid; end
    for (int i = 4; i < 10; i++) begin step(1'b0, '0, 1'b1); ov10[i] = Out_Valid; end
    check("b2b_valid_timing", DW'(ov10), DW'(10'b0011110000));
    check("b2b_sb_empty", DW'(exp_q.size()), '0);

    // Fill and overflow: fifth row is dropped.
    for (int r = 0; r < 4; r++) issue(mk_row(16'h0200 + r * 16), 1'b0);
    step(1'b1, mk_row(16'h0240), 1'b0);
    idle(3, 1'b0);
    check("fill_full", DW'(Full), DW'(1));
    check("fill_count", DW'(Count), DW'(DEPTH));
    check("fill_no_ovf_yet", DW'(Overflow), '0);
    step(1'b0, '0, 1'b0);
    check("ovf_set", DW'(Overflow), DW'(1));
    check("ovf_count_held", DW'(Count), DW'(DEPTH));
    idle(8, 1'b1);
    check("ovf_drained", DW'(Count), '0);
    check("ovf_sticky", DW'(Overflow), DW'(1));
    check("ovf_sb_empty", DW'(exp_q.size()), '0);
    Clear = 1'b1;
    step(1'b0, '0, 1'b0);
    Clear = 1'b0;
    check("clear_drops_ovf", DW'(Overflow), '0);

    // Full with simultaneous pop: push accepted, pushed row comes last.
    for (int r = 0; r < 4; r++) issue(mk_row(16'h0300 + r * 16), 1'b0);
    idle(4, 1'b0);
    issue(mk_row(16'h0340), 1'b0);
    idle(2, 1'b0);
    step(1'b0, '0, 1'b1);
    check("fpop_full_before", DW'(Full), DW'(1));
    step(1'b0, '0, 1'b0);
    check("fpop_count_4", DW'(Count), DW'(DEPTH));
    check("fpop_no_ovf", DW'(Overflow), '0);
    idle(8, 1'b1);
    check("fpop_drained", DW'(Count), '0);
    check("fpop_sb_empty", DW'(exp_q.size()), '0);

    // Random backpressure over 20 rows, never risking a drop.
    pop_cnt = 0;
    sent    = 0;
    cyc     = 0;
    while (sent < 20 && cyc < 600) begin
      pend = 0;
      for (int k = 0; k < COLS; k++) if (sl_v[k]) pend++;
      if (int'(Count) + pend + 1 <= DEPTH && $urandom_range(0, 1) == 1) begin
        issue(mk_row(16'h1000 + sent * 16), 1'($urandom_range(0, 1)));
        sent++;
      end else begin
        step(1'b0, '0, 1'($urandom_range(0, 1)));
      end
      cyc++;
    end
    cyc = 0;
    while ((exp_q.size() != 0 || Count != '0) && cyc < 200) begin
      step(1'b0, '0, 1'($urandom_range(0, 1)));
      cyc++;
    end
    check("bp_rows_sent", DW'(sent), DW'(20));
    check("bp_rows_delivered", DW'(pop_cnt), DW'(20));
    check("bp_no_ovf", DW'(Overflow), '0);

    // Asynchronous reset with two rows queued and two in the deskew lines.
    issue(mk_row(16'h2000), 1'b0);
    issue(mk_row(16'h2010), 1'b0);
    idle(4, 1'b0);
    check("rst_pre_count", DW'(Count), DW'(2));
    issue(mk_row(16'h2020), 1'b0);
    issue(mk_row(16'h2030), 1'b0);
    #2 RST = 1'b0;
    #1;
    check_zero("async_rst");
    flush_model();
    @(posedge CLK);
    @(posedge CLK);
    #3 RST = 1'b1;
    any_v = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1'b0, '0, 1'b1); any_v |= Out_Valid; end
    check("rst_no_stale", DW'(any_v), '0);

    // Same scenario flushed by Clear.
    issue(mk_row(16'h3000), 1'b0);
    issue(mk_row(16'h3010), 1'b0);
    idle(4, 1'b0);
    check("clr_pre_count", DW'(Count), DW'(2));
    issue(mk_row(16'h3020), 1'b0);
    issue(mk_row(16'h3030), 1'b0);
    Clear = 1'b1;
    step(1'b0, '0, 1'b1);
    Clear = 1'b0;
    flush_model();
    check_zero("sync_clear");
    any_v = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1'b0, '0, 1'b1); any_v |= Out_Valid; end
    check("clr_no_stale", DW'(any_v), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits at the bottom edge of the weight-stationary systolic array and receives the PsumOut bus of every bottom-row processing element.
- Psums leave the array skewed: column c's result for a given row arrives c cycles after column 0's.
- The block deskews each row into one aligned vector and buffers aligned rows in a FIFO.
- The FIFO drains through a valid/ready stream to the output writer, and the block reports Full back to the array controller for stalling.

Parameters:
- WIDTH, 8, PE operand width; each psum is 2*WIDTH bits.
- COLS, 4, number of array columns (>=2).
- DEPTH, 4, FIFO depth in aligned rows (power of 2, >=2).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous active-low reset.
- Clear  input  1  synchronous flush of all state; also clears Overflow.
- Row_Valid  input  1  column 0 psum for a new row is valid this cycle.
- PsumIn  input  COLS*2*WIDTH  bottom-row PsumOut values; column c occupies bits [c*2W +: 2W].
- Out_Valid  output  1  Out_Data holds the FIFO head row.
- Out_Ready  input  1  consumer accepts the head row when high together with Out_Valid.
- Out_Data  output  COLS*2*WIDTH  aligned row, using the same column packing as PsumIn.
- Full  output  1  FIFO occupancy == DEPTH.
- Count  output  $clog2(DEPTH)+1  FIFO occupancy.
- Overflow  output  1  sticky flag: an aligned row was dropped.

Behaviour:
- Reset (RST low, any time, asynchronous):
  - Delay lines, valid pipeline, FIFO pointers, Count and Overflow go to 0.
  - Out_Valid=0, Full=0, Out_Data=0.
  - Any row in flight is discarded.
- Skew model: a row whose Row_Valid is high in cycle t presents column c on PsumIn in cycle t+c. The block samples column c in that cycle. Values on PsumIn in other cycles are ignored.
- Deskew:
  - Column c passes through COLS-1-c registers that shift every cycle, with no enable.
  - Column COLS-1 has no register and is taken directly from PsumIn.
  - Row_Valid passes through a COLS-1 stage valid pipeline.
  - In cycle t+COLS-1 the aligned row and the delayed valid (push) appear together.
- Push: on the rising edge ending cycle t+COLS-1, if push=1, the aligned row is written to the FIFO.
  - Out_Valid goes high in cycle t+COLS when the FIFO was empty.
  - Total latency, Row_Valid to Out_Valid, is COLS cycles.
- Back-to-back rows: Row_Valid may be high every cycle. Rows overlap in the deskew lines and are all captured.
- Pop: occurs when Out_Valid && Out_Ready at the rising edge; the read pointer advances.
  - Out_Data is the combinational read of the head entry.
  - Out_Data and Out_Valid must stay stable while Out_Valid=1 and Out_Ready=0.
  - Pop when empty has no effect.
- Push while full:
  - If a pop occurs in the same cycle, the push is accepted and Count is unchanged.
  - Otherwise the row is dropped, FIFO contents are unchanged, and Overflow is set at that edge and held until RST or Clear.
- Push and pop in the same cycle on a non-full FIFO: both occur and Count is unchanged. A push into an empty FIFO is never visible as Out_Valid in the same cycle (no bypass).
- Pointers: wrap modulo DEPTH, with Count tracking occupancy exactly. Full = (Count==DEPTH). Out_Valid = (Count!=0).
- Arithmetic: no arithmetic on data; psums pass through unmodified at 2*WIDTH bits.
- Clear (synchronous, takes priority over push and pop in the same cycle): the next state equals the reset state.

Test Plan:
- Single row, COLS=4, WIDTH=8:
  - Stimulus: Row_Valid at cycle 0; PsumIn column c = 16'h0100+c in cycle c; Out_Ready=1.
  - Required: Out_Valid exactly in cycle 4, Out_Data = {0103,0102,0101,0100}, Count returns to 0.
- Back-to-back rows:
  - Stimulus: Row_Valid for 4 consecutive cycles, row r column c = r*16+c; Out_Ready=1.
  - Required: 4 consecutive Out_Valid cycles (4–7), rows in order with no column mixing between rows.
- Fill and overflow:
  - Stimulus: Out_Ready=0; push 5 rows.
  - Required: Full=1 and Count=4 after the 4th push. The 5th row is dropped and Overflow=1. Raising Out_Ready then yields rows 0–3 only.
- Full with simultaneous pop:
  - Stimulus: FIFO full; Out_Ready=1 in the same cycle as a push.
  - Required: Count stays 4, Overflow stays 0, and the pushed row appears last.
- Backpressure stability:
  - Stimulus: Out_Ready toggles 0/1 randomly over 20 rows.
  - Required: every row delivered exactly once and in order; Out_Data stable while stalled.
- Reset and Clear mid-operation:
  - Stimulus: RST low asynchronously while rows are in the deskew lines and 2 rows are queued.
  - Required: outputs go to 0 immediately and no stale row emerges after release. Repeating with Clear gives an identical result at the next edge.
